// File: rtl/timer_pkg.sv
// Shared state encoding for the down_timer FSM.
package timer_pkg;

    localparam int ST_W = 2;

    typedef logic [ST_W-1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/cnt_dn.sv
// WIDTH-bit down counter with sync clear, load and gated decrement.
// Also provides zero and one flags for the controlling FSM.
module cnt_dn #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_ld,
    input  logic [WIDTH-1:0] i_ld_val,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_zero,
    output logic             o_one
);

    logic [WIDTH-1:0] r_cnt;

    // The zero guard keeps the count from ever wrapping below 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_ld) begin
            r_cnt <= i_ld_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_zero = (r_cnt == '0);
    assign o_one  = (r_cnt == WIDTH'(1));

endmodule

// File: rtl/down_timer.sv
// Loadable down-counting timer with reload register, optional auto-reload,
// busy while running and a one-cycle done pulse on expiry.
module down_timer
    import timer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int HIGH  = WIDTH - 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld,
    input  logic [HIGH:0] in,
    input  logic        start,
    input  logic        stop,
    input  logic        dec,
    input  logic        auto,
    output logic [HIGH:0] out,
    output logic        busy,
    output logic        done
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [HIGH:0] r_reload;

    logic          w_cnt_ld;
    logic [HIGH:0] w_cnt_val;
    logic          w_cnt_dec;
    logic [HIGH:0] w_cnt;
    logic          w_cnt_zero;
    logic          w_cnt_one;

    cnt_dn #(
        .WIDTH (HIGH + 1)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_ld     (w_cnt_ld),
        .i_ld_val (w_cnt_val),
        .i_dec    (w_cnt_dec),
        .o_cnt    (w_cnt),
        .o_zero   (w_cnt_zero),
        .o_one    (w_cnt_one)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_reload <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (ld) begin
                r_reload <= in;
            end
        end
    end

    // Next state and counter control; priority ld > stop > start > dec.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_ld    = 1'b0;
        w_cnt_val   = in;
        w_cnt_dec   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (ld) begin
                    w_cnt_ld = 1'b1;
                end else if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (start) begin
                    w_state_nxt = w_cnt_zero ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (ld) begin
                    w_cnt_ld    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (dec) begin
                    w_cnt_dec = 1'b1;
                    if (w_cnt_one) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                if (ld) begin
                    w_cnt_ld = 1'b1;
                end else if (!stop && auto && (r_reload != '0)) begin
                    // A zero reload falls through to IDLE so the block cannot spin.
                    w_cnt_ld    = 1'b1;
                    w_cnt_val   = r_reload;
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (r_state == ST_RUN);
        done = (r_state == ST_DONE);
        out  = w_cnt;
    end

endmodule
